duart_rx: RTL and testbench

- Debug-UART receive stage, the downstream consumer of the duart serial line. Pairs with duart's txd for loopback tests and with external host TX in the SoC.
- Deserialises 8N1 frames at a programmable ETU (clocks per bit). Buffers bytes in a small FIFO and presents them on a valid/ready byte stream.
- Flags framing and overflow errors as sticky status bits.

---
 rtl/duart_pkg.sv | 10 +
 rtl/duart_rx_fifo.sv | 57 +++++
 rtl/duart_rx.sv | 153 +++++++++++++++
 tb/tb_duart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/duart_pkg.sv
// Shared types and constants for the debug-UART receive path.
// Imported by duart_rx and duart_rx_fifo.
package duart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} duart_rx_state_e;

    localparam int DUART_MIN_ETU   = 4;
    localparam int DUART_DATA_BITS = 8;

endpackage

// File: rtl/duart_rx_fifo.sv
// Small synchronous byte FIFO for duart_rx; head read straight from storage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module duart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    output logic       full,
    output logic       drop,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/duart_rx.sv
// Debug-UART 8N1 receiver: synchroniser, bit FSM, byte FIFO, sticky errors.
// Define DUART_RX_BREAK_EN to add the brk output for all-zero framing errors.
module duart_rx
    import duart_pkg::*;
#(
    parameter int ETU_W      = 16,
    parameter int INITETU    = 'd32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxd,
    input  logic [ETU_W-1:0] etu,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             frame_err,
    output logic             ovf,
    input  logic             err_clr,
    output logic             busy
`ifdef DUART_RX_BREAK_EN
    ,
    output logic             brk
`endif
);

    logic             s1;
    logic             rxs;
    logic             armed;
    duart_rx_state_e  state;
    logic [ETU_W-1:0] cnt;
    logic [ETU_W-1:0] e_q;
    logic [ETU_W-1:0] e_eff;
    logic [2:0]       bitn;
    logic [7:0]       shreg;
    logic             half_hit;
    logic             bit_hit;
    logic             stop_hit;
    logic             push;
    logic             fe_evt;
    logic             fe_set;
    logic             drop;
    logic             empty;
    logic             full;

    always_comb begin
        e_eff = etu;
        if (etu == '0) begin
            e_eff = ETU_W'(INITETU);
        end else if (etu < ETU_W'(DUART_MIN_ETU)) begin
            e_eff = ETU_W'(DUART_MIN_ETU);
        end
    end

    assign half_hit = (cnt == (e_q >> 1) - ETU_W'(1));
    assign bit_hit  = (cnt == e_q - ETU_W'(1));
    assign stop_hit = (state == STOP) && bit_hit;
    assign push     = stop_hit && rxs;
    assign fe_evt   = stop_hit && !rxs;
    assign busy     = (state != IDLE);
    assign m_valid  = !empty;

`ifdef DUART_RX_BREAK_EN
    logic brk_set;
    assign brk_set = fe_evt && (shreg == 8'h00);
    assign fe_set  = fe_evt && (shreg != 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            brk <= 1'b0;
        end else begin
            brk <= (brk && !err_clr) || brk_set;
        end
    end
`else
    assign fe_set = fe_evt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 1'b1;
            rxs       <= 1'b1;
            armed     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            e_q       <= ETU_W'(INITETU);
            bitn      <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            s1        <= rxd;
            rxs       <= s1;
            frame_err <= (frame_err && !err_clr) || fe_set;
            ovf       <= (ovf && !err_clr) || drop;
            cnt       <= cnt + ETU_W'(1);
            unique case (state)
                IDLE: begin
                    if (armed && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                        e_q   <= e_eff;
                    end else if (rxs) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (half_hit) begin
                        cnt   <= '0;
                        bitn  <= '0;
                        state <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'(DUART_DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        cnt   <= '0;
                        state <= IDLE;
                        // a low stop must see the line high again before rearming
                        if (!rxs) begin
                            armed <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    duart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wdata(shreg),
        .full (full),
        .drop (drop),
        .pop  (m_valid && m_ready),
        .rdata(m_data),
        .empty(empty)
    );

endmodule

// File: tb/tb_duart_rx.sv
// Directed testbench for duart_rx: 8N1 frames, glitch, framing error,
// overflow with stalled drain, and long-low break behaviour.
module tb_duart_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxd;
    logic [15:0] etu;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        frame_err;
    logic        ovf;
    logic        err_clr;
    logic        busy;
`ifdef DUART_RX_BREAK_EN
    logic        brk;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int last_rise = 0;
    int vcount = 0;
    logic mv_prev = 1'b0;
    logic [7:0] rxq [$];

    always #5 clk = ~clk;

    duart_rx dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .etu      (etu),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .frame_err(frame_err),
        .ovf      (ovf),
        .err_clr  (err_clr),
        .busy     (busy)
`ifdef DUART_RX_BREAK_EN
        ,
        .brk      (brk)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && !mv_prev) last_rise = cyc;
        if (m_valid) vcount = vcount + 1;
        if (m_valid && m_ready) rxq.push_back(m_data);
        mv_prev = m_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stopb,
                        input int e);
        rxd = 1'b0;
        fall_cyc = cyc;
        tick(e);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(e);
        end
        rxd = stopb;
        tick(e);
        rxd = 1'b1;
        tick(8);
    endtask

    int n0;
    int v0;
    int lat;

    initial begin
        reset = 1'b1;
        rxd = 1'b1;
        etu = 16'd32;
        m_ready = 1'b1;
        err_clr = 1'b0;
        tick(3);
        reset = 1'b0;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        tick(4);

        // 0xA5 at E=32, latency and single-cycle valid
        n0 = rxq.size();
        v0 = vcount;
        send(8'hA5, 1'b1, 32);
        lat = last_rise - fall_cyc;
        chk("a5_count", rxq.size() - n0, 1);
        chk("a5_data", rxq[n0], 8'hA5);
        chk("a5_latency_window", (lat >= 305 && lat <= 308), 1);
        chk("a5_valid_cycles", vcount - v0, 1);
        chk("a5_frame_err", frame_err, 0);
        chk("a5_ovf", ovf, 0);

        // etu=0 selects INITETU, etu=2 clamps to 4
        etu = 16'd0;
        n0 = rxq.size();
        send(8'h3C, 1'b1, 32);
        chk("initetu_data", rxq[n0], 8'h3C);
        etu = 16'd2;
        send(8'h81, 1'b1, 4);
        chk("clamp_count", rxq.size() - n0, 2);
        chk("clamp_data", rxq[n0+1], 8'h81);

        // 10-cycle glitch at E=32
        etu = 16'd32;
        n0 = rxq.size();
        rxd = 1'b0;
        tick(5);
        chk("glitch_busy", busy, 1);
        tick(5);
        rxd = 1'b1;
        tick(30);
        chk("glitch_idle", busy, 0);
        chk("glitch_nopush", rxq.size() - n0, 0);
        chk("glitch_frame_err", frame_err, 0);

        // stop bit low, then recovery, then clear
        n0 = rxq.size();
        v0 = vcount;
        send(8'h55, 1'b0, 32);
        tick(8);
        chk("fe_set", frame_err, 1);
        chk("fe_no_valid", vcount - v0, 0);
        send(8'h12, 1'b1, 32);
        chk("fe_recover_count", rxq.size() - n0, 1);
        chk("fe_recover_data", rxq[n0], 8'h12);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("fe_cleared", frame_err, 0);

        // overflow with stalled consumer
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1, 32);
        end
        chk("ovf_set", ovf, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", m_valid, 1);
            chk("drain_data", m_data, i);
            tick(3);
            chk("drain_stable", m_data, i);
            m_ready = 1'b1;
            tick(1);
            m_ready = 1'b0;
        end
        chk("drain_empty", m_valid, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // line held low for 12 bit times
        m_ready = 1'b1;
        n0 = rxq.size();
        rxd = 1'b0;
        tick(12 * 32);
        rxd = 1'b1;
        tick(40);
        chk("break_nopush", rxq.size() - n0, 0);
`ifdef DUART_RX_BREAK_EN
        chk("break_brk", brk, 1);
        chk("break_frame_err", frame_err, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("break_brk_cleared", brk, 0);
`else
        chk("break_frame_err", frame_err, 1);
`endif
        chk("break_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
